interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'hE0, meaning the bus address of the first of four registers (BASE_ADDR..BASE_ADDR+3).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port BUS_DATA, inout, 8 bits: shared data bus.
REQ-005 The block SHALL have port BUS_ADDR, input, 8 bits: bus address.
REQ-006 The block SHALL have port BUS_WE, input, 1 bit: bus write enable; high = write.
REQ-007 The block SHALL have port IRQ_IN, input, 4 bits: peripheral interrupt request lines, rising-edge significant.
REQ-008 The block SHALL have port BUS_INTERRUPTS_RAISE, output, 2 bits: interrupt request lines to the processor.
REQ-009 The block SHALL have port BUS_INTERRUPTS_ACK, input, 2 bits: processor acknowledge, one-cycle pulse per line.

Function
REQ-010 Registers: BASE+0 ENABLE[3:0] RW; BASE+1 PENDING[3:0] read, write-1-to-clear; BASE+2 ROUTE[3:0] RW (bit i = processor line for source i); BASE+3 VECTOR read-only ({2'b0, src1[1:0], 2'b0, src0[1:0]}); upper unused bits read 0.
REQ-011 Writes SHALL take effect on the rising edge where BUS_WE=1 and BUS_ADDR is in range.
REQ-012 Reads SHALL use a registered drive: with BUS_WE=0 and address in range at edge N, the block drives BUS_DATA with the register value from edge N+1 for one cycle; otherwise BUS_DATA is high-Z.
REQ-013 IRQ_IN SHALL be registered once and edge-detected; a 0->1 transition on IRQ_IN[i] sets PENDING[i] on the following edge, regardless of ENABLE.
REQ-014 A source is eligible for line L when PENDING[i]=1, ENABLE[i]=1 and ROUTE[i]=L.
REQ-015 Each line SHALL run an independent two-state FSM: IDLE and RAISED.
REQ-016 IDLE->RAISED on the first edge at which any source is eligible for the line: the lowest-index eligible source is latched as the line's served source; RAISE[L] goes high the same edge.
REQ-017 In RAISED, RAISE[L] SHALL stay high until BUS_INTERRUPTS_ACK[L]=1; on that edge: PENDING[served] cleared, VECTOR field for L updated to served index, FSM->IDLE, RAISE[L] low.
REQ-018 After an ACK the line SHALL spend at least one cycle in IDLE (RAISE low) before re-raising.
REQ-019 Changes to ENABLE, ROUTE or PENDING during RAISED SHALL NOT retract RAISE or change the latched served source.
REQ-020 An ACK on a line in IDLE SHALL be ignored.
REQ-021 Simultaneous set and clear of PENDING[i] (edge detect vs. W1C or ACK clear) SHALL leave PENDING[i]=1.
REQ-022 Both lines MAY be raised simultaneously; both ACKs in one cycle are processed independently.

Reset
REQ-023 When RESET=1 at an edge: ENABLE=0, PENDING=0, ROUTE=0, VECTOR=0, both FSMs IDLE, RAISE=2'b00, BUS_DATA high-Z, and the edge-detect register loaded with the current IRQ_IN so no spurious edge is seen.
REQ-024 Reset mid-RAISED SHALL drop RAISE on that edge; any outstanding ACK is then ignored per REQ-020.

Verification
REQ-025 Write ENABLE=4'h3 and ROUTE=0, pulse IRQ_IN[1] -> PENDING=4'h2, RAISE[0] high; ACK[0] pulse -> RAISE=0, PENDING=0, VECTOR=8'h01.
REQ-026 With ENABLE=4'hF, IRQ_IN[2] and IRQ_IN[0] rising in the same cycle -> line 0 serves 0 first (VECTOR[1:0]=0), then after ACK plus one idle cycle serves 2 (VECTOR[1:0]=2).
REQ-027 With ROUTE=4'h8 and ENABLE=4'h9, pulse IRQ_IN[3] and IRQ_IN[0] -> RAISE=2'b11; ACK=2'b11 -> VECTOR=8'h30, PENDING=0.
REQ-028 With ENABLE=0, pulse IRQ_IN[2] -> PENDING=4'h4, RAISE=0; write ENABLE=4'h4 -> RAISE[0] high; write PENDING=4'h4 while RAISED -> RAISE stays high until ACK.
REQ-029 Assert RESET while RAISE[0]=1 -> next edge RAISE=0 and all registers 0; ACK[0] afterwards -> no change; read BASE+1 -> BUS_DATA 8'h00 one cycle later, then high-Z.

Source files
------------

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Four-source interrupt controller with a four-register bus
//               window (ENABLE, PENDING, ROUTE, VECTOR). It edge-detects
//               IRQ_IN and routes each source to one of two processor lines.
//               Each line raises, holds until acknowledged, and records the
//               served source in VECTOR.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [3:0] IRQ_IN,
    output logic [1:0] BUS_INTERRUPTS_RAISE,
    input  logic [1:0] BUS_INTERRUPTS_ACK
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_raised = 1'b1;

    localparam logic [1:0] c_reg_enable  = 2'd0;
    localparam logic [1:0] c_reg_pending = 2'd1;
    localparam logic [1:0] c_reg_route   = 2'd2;
    localparam logic [1:0] c_reg_vector  = 2'd3;

    logic [3:0] r_enable;
    logic [3:0] r_pending;
    logic [3:0] r_route;
    logic [3:0] r_irq_prev;
    logic [0:0] r_state  [2];
    logic [1:0] r_served [2];
    logic [1:0] r_vec    [2];
    logic [1:0] r_raise;
    logic       r_rd_en;
    logic [7:0] r_rd_data;

    logic [7:0] w_offset;
    logic       w_in_range;
    logic [1:0] w_reg_sel;
    logic       w_wr;
    logic       w_rd;
    logic [3:0] w_irq_rise;
    logic [3:0] w_w1c;
    logic [3:0] w_ack_clr;
    logic [3:0] w_pending_nxt;
    logic [3:0] w_elig [2];
    logic [7:0] w_vector;
    logic [7:0] w_rd_mux;
    wire        w_unused_bus = &{1'b0, BUS_DATA[7:4]};

    // Lowest-index set bit; callers only use it when the vector is non-zero.
    function automatic logic [1:0] f_lowest(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = i[1:0];
        end
        return r;
    endfunction

    // Address decode is relative to BASE_ADDR; the 8-bit subtraction wraps, so
    // anything below the base lands far out of range.
    assign w_offset   = BUS_ADDR - BASE_ADDR;
    assign w_in_range = (w_offset[7:2] == 6'd0);
    assign w_reg_sel  = w_offset[1:0];
    assign w_wr       = BUS_WE & w_in_range;
    assign w_rd       = ~BUS_WE & w_in_range;
    assign w_irq_rise = IRQ_IN & ~r_irq_prev;
    assign w_vector   = {2'b00, r_vec[1], 2'b00, r_vec[0]};

    // Eligibility per line, W1C mask and ACK clear mask; a new edge on the
    // same cycle as any clear wins so no request is lost.
    always_comb begin
        w_elig[0] = r_pending & r_enable & ~r_route;
        w_elig[1] = r_pending & r_enable & r_route;
        w_w1c     = (w_wr && (w_reg_sel == c_reg_pending)) ? BUS_DATA[3:0] : 4'h0;
        w_ack_clr = 4'h0;
        for (int l = 0; l < 2; l++) begin
            if ((r_state[l] == c_st_raised) && BUS_INTERRUPTS_ACK[l]) begin
                w_ack_clr[r_served[l]] = 1'b1;
            end
        end
        w_pending_nxt = (r_pending & ~(w_w1c | w_ack_clr)) | w_irq_rise;
    end

    // Read mux for the registered bus drive.
    always_comb begin
        w_rd_mux = 8'h00;
        case (w_reg_sel)
            c_reg_enable:  w_rd_mux = {4'h0, r_enable};
            c_reg_pending: w_rd_mux = {4'h0, r_pending};
            c_reg_route:   w_rd_mux = {4'h0, r_route};
            c_reg_vector:  w_rd_mux = w_vector;
            default:       w_rd_mux = 8'h00;
        endcase
    end

    // Register file and edge-detect history; reset samples IRQ_IN so a line
    // already high at reset release is not seen as a new edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_enable   <= 4'h0;
            r_pending  <= 4'h0;
            r_route    <= 4'h0;
            r_irq_prev <= IRQ_IN;
        end else begin
            r_irq_prev <= IRQ_IN;
            r_pending  <= w_pending_nxt;
            if (w_wr && (w_reg_sel == c_reg_enable)) r_enable <= BUS_DATA[3:0];
            if (w_wr && (w_reg_sel == c_reg_route))  r_route  <= BUS_DATA[3:0];
        end
    end

    // Per-line IDLE/RAISED machine; the served source is frozen while raised
    // so register changes cannot retract or redirect an outstanding request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int l = 0; l < 2; l++) begin
                r_state[l]  <= c_st_idle;
                r_served[l] <= 2'd0;
                r_vec[l]    <= 2'd0;
            end
            r_raise <= 2'b00;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (r_state[l] == c_st_idle) begin
                    if (|w_elig[l]) begin
                        r_state[l]  <= c_st_raised;
                        r_served[l] <= f_lowest(w_elig[l]);
                        r_raise[l]  <= 1'b1;
                    end
                end else begin
                    if (BUS_INTERRUPTS_ACK[l]) begin
                        r_state[l] <= c_st_idle;
                        r_vec[l]   <= r_served[l];
                        r_raise[l] <= 1'b0;
                    end
                end
            end
        end
    end

    // Registered read drive: one cycle of data after the addressing edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_rd_en   <= w_rd;
            r_rd_data <= w_rd_mux;
        end
    end

    assign BUS_DATA             = r_rd_en ? r_rd_data : 8'hzz;
    assign BUS_INTERRUPTS_RAISE = r_raise;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed self-checking bench for interrupt_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    localparam logic [7:0] c_base = 8'hE0;
    localparam logic [7:0] c_en   = c_base + 8'd0;
    localparam logic [7:0] c_pend = c_base + 8'd1;
    localparam logic [7:0] c_rte  = c_base + 8'd2;
    localparam logic [7:0] c_vec  = c_base + 8'd3;
    localparam logic [7:0] c_idle_addr = 8'h00;

    logic       clk;
    logic       rst;
    wire  [7:0] bus_data;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [3:0] irq_in;
    logic [1:0] raise;
    logic [1:0] ack;
    logic [7:0] tb_drv;
    logic       tb_oe;
    logic [7:0] rdv;

    int n_checks;
    int n_errors;

    assign bus_data = tb_oe ? tb_drv : 8'hzz;

    interrupt_controller #(.BASE_ADDR(c_base)) u_dut (
        .CLK                  (clk),
        .RESET                (rst),
        .BUS_DATA             (bus_data),
        .BUS_ADDR             (bus_addr),
        .BUS_WE               (bus_we),
        .IRQ_IN               (irq_in),
        .BUS_INTERRUPTS_RAISE (raise),
        .BUS_INTERRUPTS_ACK   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b1;
        tb_drv   = d;
        tb_oe    = 1'b1;
        tick();
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        bus_addr = c_idle_addr;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b0;
        tick();
        d        = bus_data;
        bus_addr = c_idle_addr;
    endtask

    task automatic pulse(input logic [3:0] m);
        irq_in = m;
        tick();
        irq_in = 4'h0;
    endtask

    task automatic do_ack(input logic [1:0] m);
        ack = m;
        tick();
        ack = 2'b00;
    endtask

    // Bus must be released: tb drives 00 and must read 00 back.
    task automatic check_hiz(input string tag);
        tb_drv = 8'h00;
        tb_oe  = 1'b1;
        #1;
        check(tag, bus_data, 8'h00);
        tb_oe  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; bus_addr = c_idle_addr; bus_we = 1'b0; irq_in = 4'h0;
        ack = 2'b00; tb_drv = 8'h00; tb_oe = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_raise", {6'd0, raise}, 8'h00);
        rd(c_en, rdv);   check("reset_enable", rdv, 8'h00);

        // Single source on line 0
        wr(c_en, 8'h03);
        wr(c_rte, 8'h00);
        pulse(4'h2);
        tick();
        check("t1_raise", {6'd0, raise}, 8'h01);
        rd(c_pend, rdv); check("t1_pending", rdv, 8'h02);
        do_ack(2'b01);
        check("t1_raise_ack", {6'd0, raise}, 8'h00);
        rd(c_pend, rdv); check("t1_pending_ack", rdv, 8'h00);
        rd(c_vec, rdv);  check("t1_vector", rdv, 8'h01);
        rd(c_en, rdv);   check("t1_enable_rd", rdv, 8'h03);
        tick();
        check_hiz("t1_bus_release");

        // Priority: sources 0 and 2 together
        do_reset();
        wr(c_en, 8'h0F);
        pulse(4'h5);
        tick();
        check("t2_raise_a", {6'd0, raise}, 8'h01);
        do_ack(2'b01);
        check("t2_idle_gap", {6'd0, raise}, 8'h00);
        tick();
        check("t2_raise_b", {6'd0, raise}, 8'h01);
        rd(c_vec, rdv);  check("t2_vector_a", rdv, 8'h00);
        do_ack(2'b01);
        rd(c_vec, rdv);  check("t2_vector_b", rdv, 8'h02);
        rd(c_pend, rdv); check("t2_pending", rdv, 8'h00);

        // Both lines at once
        do_reset();
        wr(c_rte, 8'h08);
        wr(c_en, 8'h09);
        pulse(4'h9);
        tick();
        check("t3_raise", {6'd0, raise}, 8'h03);
        do_ack(2'b11);
        check("t3_raise_ack", {6'd0, raise}, 8'h00);
        rd(c_vec, rdv);  check("t3_vector", rdv, 8'h30);
        rd(c_pend, rdv); check("t3_pending", rdv, 8'h00);

        // Pending regardless of enable; raised line survives W1C
        do_reset();
        pulse(4'h4);
        tick();
        check("t4_raise_dis", {6'd0, raise}, 8'h00);
        rd(c_pend, rdv); check("t4_pending", rdv, 8'h04);
        wr(c_en, 8'h04);
        tick();
        check("t4_raise_en", {6'd0, raise}, 8'h01);
        wr(c_pend, 8'h04);
        check("t4_raise_w1c", {6'd0, raise}, 8'h01);
        tick();
        check("t4_raise_hold", {6'd0, raise}, 8'h01);
        rd(c_pend, rdv); check("t4_pending_w1c", rdv, 8'h00);
        do_ack(2'b01);
        check("t4_raise_ack", {6'd0, raise}, 8'h00);
        rd(c_vec, rdv);  check("t4_vector", rdv, 8'h02);
        // Set and W1C of the same bit in one cycle keeps it set
        irq_in = 4'h2;
        wr(c_pend, 8'h02);
        irq_in = 4'h0;
        rd(c_pend, rdv); check("t4_set_wins", rdv, 8'h02);
        // ACK on an idle line does nothing
        do_ack(2'b01);
        rd(c_vec, rdv);  check("t4_idle_ack_vec", rdv, 8'h02);
        rd(c_pend, rdv); check("t4_idle_ack_pend", rdv, 8'h02);

        // Reset while raised, with IRQ_IN[3] rising on the reset edge
        do_reset();
        wr(c_en, 8'h01);
        pulse(4'h1);
        tick();
        check("t5_raise", {6'd0, raise}, 8'h01);
        irq_in = 4'h8;
        do_reset();
        check("t5_raise_rst", {6'd0, raise}, 8'h00);
        do_ack(2'b01);
        check("t5_raise_ack", {6'd0, raise}, 8'h00);
        tick();
        rd(c_en, rdv);   check("t5_enable", rdv, 8'h00);
        rd(c_rte, rdv);  check("t5_route", rdv, 8'h00);
        rd(c_vec, rdv);  check("t5_vector", rdv, 8'h00);
        rd(c_pend, rdv); check("t5_pending", rdv, 8'h00);
        tick();
        check_hiz("t5_bus_release");
        irq_in = 4'h0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
